// File: rtl/dcm_lock_supervisor.sv
// Supervises a DCM: pulses its reset, waits for a filtered lock, then watches
// LOCKED and a monitored-clock toggle; retries a bounded number of times before faulting.
`timescale 1ns/1ps
module dcm_lock_supervisor #(
  parameter int RST_PULSE_CYCLES = 128,
  parameter int LOCK_TIMEOUT     = 4096,
  parameter int LOCK_FILTER      = 16,
  parameter int TOGGLE_TIMEOUT   = 64,
  parameter int MAX_RETRIES      = 8
) (
  input  logic       wb_clk_master_in,
  input  logic       RESET,
  input  logic       LOCKED,
  input  logic       CLK_MON,
  output logic       DCM_RST,
  output logic       READY,
  output logic       FAULT,
  output logic [3:0] RETRY_CNT
);

  localparam int RW = $clog2(RST_PULSE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int FW = $clog2(LOCK_FILTER + 1);
  localparam int GW = $clog2(TOGGLE_TIMEOUT + 1);

  localparam logic [RW-1:0] RST_LAST     = RW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [FW-1:0] FILTER_DONE  = FW'(LOCK_FILTER);
  localparam logic [GW-1:0] TOGGLE_LIMIT = GW'(TOGGLE_TIMEOUT);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    S_RST       = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RUN       = 2'd2,
    S_FAULT     = 2'd3
  } state_t;

  state_t        state;
  logic          lock_ff1, locked_s;
  logic          mon_ff1, mon_ff2, mon_ff3;
  logic          mon_edge;
  logic [RW-1:0] rst_cnt;
  logic [TW-1:0] timer;
  logic [FW-1:0] filter;
  logic [GW-1:0] toggle_cnt;
  logic [3:0]    retry_next;
  logic          attempt_fail;

  always_ff @(posedge wb_clk_master_in) begin
    if (RESET) begin
      lock_ff1 <= 1'b0;
      locked_s <= 1'b0;
      mon_ff1  <= 1'b0;
      mon_ff2  <= 1'b0;
      mon_ff3  <= 1'b0;
    end else begin
      lock_ff1 <= LOCKED;
      locked_s <= lock_ff1;
      mon_ff1  <= CLK_MON;
      mon_ff2  <= mon_ff1;
      mon_ff3  <= mon_ff2;
    end
  end

  assign mon_edge   = mon_ff2 ^ mon_ff3;
  assign retry_next = (RETRY_CNT == 4'hF) ? RETRY_CNT : RETRY_CNT + 4'd1;

  // A completed filter takes priority over a timeout landing on the same edge.
  always_comb begin
    attempt_fail = 1'b0;
    case (state)
      S_WAIT_LOCK: attempt_fail = (filter != FILTER_DONE) && (timer == TIMER_LAST);
      S_RUN:       attempt_fail = !locked_s || (toggle_cnt == TOGGLE_LIMIT);
      default:     attempt_fail = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_master_in) begin
    if (RESET) begin
      state      <= S_RST;
      DCM_RST    <= 1'b1;
      READY      <= 1'b0;
      FAULT      <= 1'b0;
      RETRY_CNT  <= 4'd0;
      rst_cnt    <= '0;
      timer      <= '0;
      filter     <= '0;
      toggle_cnt <= '0;
    end else if (attempt_fail) begin
      RETRY_CNT <= retry_next;
      READY     <= 1'b0;
      if (retry_next >= RETRY_LIMIT) begin
        state   <= S_FAULT;
        DCM_RST <= 1'b0;
        FAULT   <= 1'b1;
      end else begin
        state   <= S_RST;
        DCM_RST <= 1'b1;
        rst_cnt <= '0;
      end
    end else begin
      case (state)
        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            state   <= S_WAIT_LOCK;
            DCM_RST <= 1'b0;
            timer   <= '0;
            filter  <= '0;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (filter == FILTER_DONE) begin
            state      <= S_RUN;
            READY      <= 1'b1;
            toggle_cnt <= '0;
          end else begin
            timer  <= timer + TW'(1);
            filter <= locked_s ? filter + FW'(1) : '0;
          end
        end
        S_RUN: begin
          toggle_cnt <= mon_edge ? '0 : toggle_cnt + GW'(1);
        end
        S_FAULT: begin
          DCM_RST <= 1'b0;
          READY   <= 1'b0;
          FAULT   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Randomized directed scenarios for dcm_lock_supervisor, compared every cycle
// against an event-time model derived from the supervisor's timing rules.
`timescale 1ns/1ps
module tb_dcm_lock_supervisor;

  localparam int RSTP = 128;
  localparam int LT   = 4096;
  localparam int LF   = 16;
  localparam int TT   = 64;
  localparam int MAXR = 8;
  localparam int ATT  = RSTP + LT;

  logic       clk     = 1'b0;
  logic       RESET   = 1'b1;
  logic       LOCKED  = 1'b0;
  logic       CLK_MON = 1'b0;
  logic       DCM_RST, READY, FAULT;
  logic [3:0] RETRY_CNT;
  int         checks  = 0;
  int         errors  = 0;

  dcm_lock_supervisor #(
    .RST_PULSE_CYCLES(RSTP),
    .LOCK_TIMEOUT(LT),
    .LOCK_FILTER(LF),
    .TOGGLE_TIMEOUT(TT),
    .MAX_RETRIES(MAXR)
  ) dut (
    .wb_clk_master_in(clk),
    .RESET(RESET),
    .LOCKED(LOCKED),
    .CLK_MON(CLK_MON),
    .DCM_RST(DCM_RST),
    .READY(READY),
    .FAULT(FAULT),
    .RETRY_CNT(RETRY_CNT)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected {DCM_RST, READY, FAULT, RETRY_CNT} k cycles after reset release.
  // d<0: lock never achieved; f: cycle of a one-cycle LOCKED drop; t_last: last CLK_MON toggle.
  function automatic logic [6:0] reference(input int k, input int d, input int f, input int t_last);
    int ff, r1, a;
    if (d < 0) begin
      a = k / ATT;
      if (a >= MAXR) return {1'b0, 1'b0, 1'b1, 4'(MAXR)};
      return {(k % ATT) < RSTP, 1'b0, 1'b0, 4'(a)};
    end
    // two synchronizer flops, LF filtered samples, one decision edge
    r1 = (d + 2 + LF + 1 > RSTP + LF + 1) ? d + 2 + LF + 1 : RSTP + LF + 1;
    ff = -1;
    if (f >= 0) ff = f + 3;
    else if (t_last >= 0) ff = t_last + 3 + TT + 1;
    if (ff >= 0 && k >= ff) return {k < ff + RSTP, k >= ff + RSTP + LF + 1, 1'b0, 4'd1};
    return {k < RSTP, k >= r1, 1'b0, 4'd0};
  endfunction

  task automatic check_output(input string tag, input logic [6:0] observed,
                              input logic [6:0] expected, output bit ok);
    checks++;
    ok = (observed === expected);
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
    end
  endtask

  task automatic start_case(input logic lock_init);
    bit ok;
    RESET   = 1'b1;
    LOCKED  = lock_init;
    CLK_MON = 1'b0;
    tick();
    check_output("reset_values", {DCM_RST, READY, FAULT, RETRY_CNT}, 7'b1000000, ok);
    repeat ($urandom_range(3, 0)) tick();
    RESET = 1'b0;
  endtask

  // ph>=0 selects the 10-high/1-low LOCKED glitch pattern; s>=0 stops CLK_MON from cycle s.
  task automatic apply_stimulus(input string name, input int d, input int p, input int f,
                                input int s, input int ph, input int k_end);
    bit ok;
    int t_last;
    t_last = (s >= 0) ? ((s - 1) / p) * p : -1;
    for (int k = 0; k <= k_end; k++) begin
      check_output($sformatf("%s k=%0d", name, k), {DCM_RST, READY, FAULT, RETRY_CNT},
                   reference(k, d, f, t_last), ok);
      if (!ok) break;
      if (ph >= 0) LOCKED = ((k + ph) % 11) != 10;
      else LOCKED = (d >= 0) && (k >= d) && (k != f);
      if (k > 0 && k % p == 0 && (s < 0 || k < s)) CLK_MON = ~CLK_MON;
      tick();
    end
  endtask

  initial begin
    int d, p, f, s, r1;
    tick();

    start_case(1'b0);
    apply_stimulus("lock_basic", 200, 10, -1, -1, -1, 260);

    d = $urandom_range(300, 20);
    p = $urandom_range(20, 3);
    r1 = (d + 19 > RSTP + LF + 1) ? d + 19 : RSTP + LF + 1;
    start_case(1'($urandom_range(1, 0)));
    apply_stimulus("lock_random", d, p, -1, -1, -1, r1 + 40);

    d = $urandom_range(250, 130);
    p = $urandom_range(20, 3);
    f = d + 19 + $urandom_range(60, 5);
    start_case(1'b0);
    apply_stimulus("lock_drop", d, p, f, -1, -1, f + 170);

    d = $urandom_range(250, 20);
    p = $urandom_range(20, 3);
    r1 = (d + 19 > RSTP + LF + 1) ? d + 19 : RSTP + LF + 1;
    s = r1 + $urandom_range(80, 30);
    start_case(1'b0);
    apply_stimulus("clock_stop", d, p, -1, s, -1, s + 150);

    start_case(1'b0);
    apply_stimulus("lock_glitch", -1, 10, -1, -1, $urandom_range(10, 0), ATT + 140);

    start_case(1'b0);
    apply_stimulus("no_lock", -1, 10, -1, -1, -1, MAXR * ATT + 200);

    start_case(1'b1);
    apply_stimulus("after_fault", 200, 10, -1, -1, -1, 260);

    start_case(1'b0);
    apply_stimulus("pre_abort", 200, 10, -1, -1, -1, $urandom_range(100, 10));
    start_case(1'b0);
    apply_stimulus("after_abort", 200, 10, -1, -1, -1, 260);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
